// File: rtl/gpu_pkg.sv
// Shared GPU definitions: bus widths, fb_writer state encoding and the pixel address helper.
package gpu_pkg;

  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned COORD_W   = 11;
  localparam int unsigned PIX_W     = FB_ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StClearWait = 2'd1,
    StClear     = 2'd2
  } fbw_state_e;

  // x + y*width as a sum of shifted copies of y; width is a constant at every call site.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int unsigned        width);
    logic [FB_ADDR_W-1:0] acc;
    acc = FB_ADDR_W'(x);
    for (int i = 0; i < FB_ADDR_W; i++) begin
      if (width[i]) begin
        acc = acc + (FB_ADDR_W'(y) << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with first-word fall-through read data and full/empty flags.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wptr_q, wptr_d;
  logic [PtrW:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q + (PtrW + 1)'(do_push);
    rptr_d = rptr_q + (PtrW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: address stage, pixel FIFO, one-deep write register and frame tracking.
// Define FB_WRITER_CLEAR_EN to build the framebuffer clear sequencer.
module fb_writer
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH   = 800,
  parameter int unsigned FB_HEIGHT  = 600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_draw,
  input  logic [COLOR_W-1:0]   in_color,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic                 in_frame_end,
  output logic                 in_ready,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  input  logic                 clear_start,
  input  logic [COLOR_W-1:0]   clear_color,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          drop_count
);

  localparam logic [COORD_W-1:0] WidthC  = COORD_W'(FB_WIDTH);
  localparam logic [COORD_W-1:0] HeightC = COORD_W'(FB_HEIGHT);

  fbw_state_e           state_q;
  logic                 pipe_valid_q, pipe_valid_d;
  logic [FB_ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic [COLOR_W-1:0]   pipe_color_q, pipe_color_d;
  logic                 fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
  logic                 frame_pend_q, frame_pend_d;
  logic [15:0]          drop_q, drop_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PIX_W-1:0]     fifo_wdata, fifo_rdata;
  logic                 xfer, in_range, out_free, drained;

  assign in_ready   = (state_q == StRun) && !fifo_full;
  assign xfer       = in_valid && in_ready;
  assign in_range   = (in_x < WidthC) && (in_y < HeightC);
  assign out_free   = !fb_we_q || fb_ready;
  assign drained    = !pipe_valid_q && fifo_empty && !fb_we_q;
  assign fifo_push  = pipe_valid_q;
  assign fifo_wdata = {pipe_addr_q, pipe_color_q};

  // in_ready implies the FIFO has room, so a valid address stage always drains on a transfer.
  always_comb begin
    pipe_valid_d = pipe_valid_q && fifo_full;
    pipe_addr_d  = pipe_addr_q;
    pipe_color_d = pipe_color_q;
    drop_d       = drop_q;
    if (xfer) begin
      pipe_valid_d = in_draw && in_range;
      pipe_addr_d  = pix_addr(in_x, in_y, FB_WIDTH);
      pipe_color_d = in_color;
      if (!in_range && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PIX_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [FB_ADDR_W-1:0] LastAddr = FB_ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [FB_ADDR_W-1:0] EndAddr  = FB_ADDR_W'(FB_WIDTH * FB_HEIGHT);

  fbw_state_e           state_d;
  logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
  logic                 clr_load;

  assign clr_load = (state_q == StClear) && out_free && (clr_addr_q != EndAddr);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    unique case (state_q)
      StRun: begin
        if (clear_start) begin
          state_d     = StClearWait;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end
      end
      StClearWait: begin
        if (drained) begin
          state_d = StClear;
        end
      end
      StClear: begin
        if (clr_load) begin
          clr_addr_d = clr_addr_q + FB_ADDR_W'(1);
        end
        if (fb_we_q && fb_ready && (fb_addr_q == LastAddr)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
    end
  end
`else
  logic unused_clear;
  assign state_q      = StRun;
  assign unused_clear = ^{clear_start, clear_color};
`endif

  // The write register reloads only once the current request has been accepted.
  always_comb begin
    fb_we_d   = fb_we_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fifo_pop  = 1'b0;
    if (out_free) begin
      fb_we_d = 1'b0;
`ifdef FB_WRITER_CLEAR_EN
      if (clr_load) begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_addr_q;
        fb_data_d = clr_color_q;
      end else
`endif
      if ((state_q != StClear) && !fifo_empty) begin
        fifo_pop               = 1'b1;
        fb_we_d                = 1'b1;
        {fb_addr_d, fb_data_d} = fifo_rdata;
      end
    end
  end

  // Frame completion is held off until the clear sequence has returned to RUN.
  assign frame_done   = frame_pend_q && drained && (state_q == StRun);
  assign frame_pend_d = (frame_pend_q && !frame_done) || in_frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_color_q <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_pend_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_color_q <= pipe_color_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_pend_q <= frame_pend_d;
      drop_q       <= drop_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign drop_count = drop_q;
  assign busy       = !fifo_empty || pipe_valid_q || fb_we_q || (state_q != StRun);

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized traffic against a
// queue-based reference model; the clear scenario is built when FB_WRITER_CLEAR_EN is defined.
module tb_fb_writer;

  localparam int W = 800;
  localparam int H = 600;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_draw = 1'b0;
  logic [7:0]  in_color = '0;
  logic [10:0] in_x = '0;
  logic [10:0] in_y = '0;
  logic        in_frame_end = 1'b0;
  logic        fb_ready = 1'b1;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        in_ready, fb_we, busy, frame_done;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [26:0] exp_q[$];
  int          exp_drop = 0;
  bit          pend = 0;
  int          left = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          prev_stall = 0;
  logic [18:0] prev_addr, last_addr;
  logic [7:0]  prev_data, last_data;
  bit          clr_mode = 0;
  int          clr_next = 0;
  logic [7:0]  clr_col = '0;

  fb_writer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H),
    .FIFO_DEPTH(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_draw     (in_draw),
    .in_color    (in_color),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_frame_end(in_frame_end),
    .in_ready    (in_ready),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .busy        (busy),
    .frame_done  (frame_done),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [10:0] x, input logic [10:0] y, input logic [7:0] c,
                         input logic d, input logic fe, output int tries);
    bit ok;
    ok = 0;
    tries = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_color = c; in_draw = d; in_frame_end = fe;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tries++;
      step();
    end
    in_valid = 1'b0;
    in_frame_end = 1'b0;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic pulse_fe();
    in_frame_end = 1'b1;
    step();
    in_frame_end = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      step();
    end
    check("drain_queue", 32'(exp_q.size()), 0);
    check("drain_busy", 32'(busy), 0);
  endtask

  // Reference model: writes expected in arrival order at x + y*W; frame end bound to the
  // writes outstanding when it arrived.
  always @(negedge clk) begin
    logic [26:0] e;
    if (reset) begin
      exp_q.delete();
      exp_drop = 0;
      pend = 0;
      left = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_we", 32'(fb_we), 1);
        check("stall_addr", 32'(fb_addr), 32'(prev_addr));
        check("stall_data", 32'(fb_data), 32'(prev_data));
      end
      prev_stall = fb_we && !fb_ready;
      prev_addr = fb_addr;
      prev_data = fb_data;
      if (frame_done) begin
        done_cnt++;
        check("done_pending", 32'(pend), 1);
        check("done_after_writes", 32'(left), 0);
        pend = 0;
      end
      if (fb_we && fb_ready) begin
        wr_cnt++;
        last_addr = fb_addr;
        last_data = fb_data;
        if (clr_mode) begin
          check("clr_addr", 32'(fb_addr), 32'(clr_next));
          check("clr_data", 32'(fb_data), 32'(clr_col));
          clr_next++;
        end else begin
          check("wr_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(e[26:8]));
            check("wr_data", 32'(fb_data), 32'(e[7:0]));
          end
        end
        if (left > 0) left--;
      end
      if (in_valid && in_ready) begin
        if (int'(in_x) >= W || int'(in_y) >= H) begin
          if (exp_drop < 65535) exp_drop++;
        end else if (in_draw) begin
          exp_q.push_back({19'(int'(in_x) + int'(in_y) * W), in_color});
        end
      end
      if (in_frame_end) begin
        pend = 1;
        left = exp_q.size();
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tries, lat, base, dbase, sent, bad;
    logic [10:0] px_x[12];
    logic [10:0] px_y[12];
    logic [7:0]  px_c[12];

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_data", 32'(fb_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_drop", 32'(drop_count), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 1);
    step();

    // Single pixel: address 10 + 2*800 = 1610, written 2-3 cycles after transfer
    base = wr_cnt;
    send_px(11'd10, 11'd2, 8'h55, 1'b1, 1'b0, tries);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (fb_we) break;
      step();
    end
    check("px_latency_ok", 32'((lat - 1) >= 2 && (lat - 1) <= 3), 1);
    step();
    check("px_addr", 32'(last_addr), 32'd1610);
    check("px_data", 32'(last_data), 32'h55);
    wait_drain(20);
    check("px_count", 32'(wr_cnt - base), 1);

    // Out-of-range pixels are dropped and counted
    base = wr_cnt;
    send_px(11'd800, 11'd0, 8'h11, 1'b1, 1'b0, tries);
    check("oor1_first_try", 32'(tries), 1);
    send_px(11'd0, 11'd600, 8'h22, 1'b1, 1'b0, tries);
    check("oor2_first_try", 32'(tries), 1);
    @(negedge clk);
    check("oor_ready", 32'(in_ready), 1);
    step();
    wait_drain(20);
    check("oor_drop", 32'(drop_count), 32'd2);
    check("oor_drop_model", 32'(drop_count), 32'(exp_drop));
    check("oor_no_write", 32'(wr_cnt - base), 0);

    // Backpressure: 12 pixels offered while fb_ready is low for 20 cycles
    for (int i = 0; i < 12; i++) begin
      px_x[i] = 11'($urandom_range(0, W - 1));
      px_y[i] = 11'($urandom_range(0, H - 1));
      px_c[i] = 8'($urandom_range(0, 255));
    end
    fb_ready = 1'b0;
    base = wr_cnt;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      if (sent < 12) begin
        in_valid = 1'b1; in_draw = 1'b1;
        in_x = px_x[sent]; in_y = px_y[sent]; in_color = px_c[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
    end
    check("bp_fill", 32'(sent), 32'(D + 2));
    check("bp_ready_low", 32'(in_ready), 0);
    check("bp_no_write", 32'(wr_cnt - base), 0);
    fb_ready = 1'b1;
    for (int c = 0; c < 100 && sent < 12; c++) begin
      in_valid = 1'b1; in_draw = 1'b1;
      in_x = px_x[sent]; in_y = px_y[sent]; in_color = px_c[sent];
      @(negedge clk);
      if (in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    wait_drain(100);
    check("bp_writes", 32'(wr_cnt - base), 12);

    // Frame end with the last pixel while memory is stalled
    fb_ready = 1'b0;
    dbase = done_cnt;
    send_px(11'd1, 11'd1, 8'hA1, 1'b1, 1'b0, tries);
    send_px(11'd2, 11'd1, 8'hA2, 1'b1, 1'b0, tries);
    send_px(11'd3, 11'd1, 8'hA3, 1'b1, 1'b1, tries);
    repeat (10) step();
    check("fe_no_early", 32'(done_cnt - dbase), 0);
    fb_ready = 1'b1;
    repeat (30) step();
    check("fe_one_pulse", 32'(done_cnt - dbase), 1);

    // Two frame ends while pending merge into one frame_done
    fb_ready = 1'b0;
    dbase = done_cnt;
    send_px(11'd7, 11'd9, 8'h77, 1'b1, 1'b0, tries);
    pulse_fe();
    step();
    pulse_fe();
    repeat (5) step();
    fb_ready = 1'b1;
    repeat (30) step();
    check("fe_merge", 32'(done_cnt - dbase), 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_draw = ($urandom_range(0, 7) != 0);
      in_x = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(W, 2047))
                                         : 11'($urandom_range(0, W - 1));
      in_y = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(H, 2047))
                                         : 11'($urandom_range(0, H - 1));
      in_color = 8'($urandom_range(0, 255));
      in_frame_end = ($urandom_range(0, 39) == 0);
      fb_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    in_frame_end = 1'b0;
    fb_ready = 1'b1;
    wait_drain(200);
    repeat (3) step();
    check("rand_drop", 32'(drop_count), 32'(exp_drop));
    check("rand_pend_cleared", 32'(pend), 0);

    // Reset during a stalled write abandons it
    fb_ready = 1'b0;
    send_px(11'd5, 11'd5, 8'hAA, 1'b1, 1'b0, tries);
    for (int i = 0; i < 10; i++) begin
      if (fb_we) break;
      step();
    end
    check("rstw_we_before", 32'(fb_we), 1);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("rstw_we_off", 32'(fb_we), 0);
    check("rstw_busy", 32'(busy), 0);
    step();
    reset = 1'b0;
    fb_ready = 1'b1;
    base = wr_cnt;
    repeat (10) step();
    check("rstw_no_write", 32'(wr_cnt - base), 0);
    check("rstw_ready", 32'(in_ready), 1);

`ifdef FB_WRITER_CLEAR_EN
    // Full clear, then a rerun interrupted by reset at write 1000
    clr_mode = 1; clr_next = 0; clr_col = 8'h00;
    base = wr_cnt;
    bad = 0;
    clear_start = 1'b1; clear_color = 8'h00;
    step();
    clear_start = 1'b0; clear_color = 8'hFF;
    for (int i = 0; i < 490000; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (in_ready) bad++;
      step();
    end
    check("clr_count", 32'(wr_cnt - base), 32'd480000);
    check("clr_ready_low", 32'(bad), 0);
    check("clr_next", 32'(clr_next), 32'd480000);
    check("clr_back_run", 32'(in_ready), 1);
    step();
    clr_next = 0; clr_col = 8'h3C;
    clear_start = 1'b1; clear_color = 8'h3C;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (clr_next >= 1000) break;
      step();
    end
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("clr_rst_we", 32'(fb_we), 0);
    step();
    reset = 1'b0;
    clr_mode = 0;
    base = wr_cnt;
    repeat (10) step();
    check("clr_rst_no_write", 32'(wr_cnt - base), 0);
    check("clr_rst_ready", 32'(in_ready), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
